// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer.
//   state_e        : controller state encoding
//   MODE_ONESHOT   : stop in DONE after the terminal tick
//   MODE_PERIODIC  : reload and keep running after the terminal tick
//   presc_width()  : prescaler counter width for a given divide ratio
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StDone
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // ceil(log2(div)) with a floor of one bit so TICK_DIV == 1 still has a counter.
    function automatic int unsigned presc_width(int unsigned div);
        return (div > 1) ? int'($clog2(div)) : 1;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
//   start       : load load_value and begin counting (sampled each edge)
//   pause       : level, freezes the countdown while high
//   abort       : return to idle (sampled each edge, highest priority)
//   auto_reload : sampled with start; 1 = periodic, 0 = one-shot
//   load_value  : initial count
//   count       : remaining count (registered)
//   busy        : running or paused
//   paused      : paused only
//   done        : one-cycle pulse at the terminal tick
interface countdown_timer_if #(
    parameter int unsigned WIDTH = 10
);
    logic             start;
    logic             pause;
    logic             abort;
    logic             auto_reload;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             done;

    modport master (
        output start, pause, abort, auto_reload, load_value,
        input  count, busy, paused, done
    );

    modport slave (
        input  start, pause, abort, auto_reload, load_value,
        output count, busy, paused, done
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides the clock by TICK_DIV to produce the count decrement strobe.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : return the prescaler to zero (takes precedence over enable)
//   enable     : advance the prescaler this edge
//   tick       : high when enabled and the prescaler is at its wrap point,
//                i.e. a decrement is due on this edge
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned   PW   = presc_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with pause, abort and one-shot/periodic modes.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : control/status bundle (slave side), all outputs registered
// Input priority on each edge is abort > start > pause.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    countdown_timer_if.slave   bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             paused_q, paused_d;

    logic presc_clear;
    logic presc_en;
    logic tick;

    // Derived from inputs and state only, so tick never feeds back into the prescaler.
    assign presc_clear = bus.abort || bus.start;
    assign presc_en    = !bus.abort && !bus.start && !bus.pause &&
                         ((state_q == StRun) || (state_q == StPaused));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (presc_clear),
        .enable (presc_en),
        .tick   (tick)
    );

    // State register (outputs included, so every output is a flop).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            paused_q <= paused_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        done_d   = 1'b0;

        if (bus.abort) begin
            state_d = StIdle;
            count_d = '0;
        end else if (bus.start) begin
            reload_d = bus.load_value;
            if (bus.load_value == '0) begin
                // Nothing to count: finish immediately, mode is irrelevant.
                mode_d  = MODE_ONESHOT;
                state_d = StDone;
                count_d = '0;
                done_d  = 1'b1;
            end else begin
                mode_d  = bus.auto_reload;
                state_d = StRun;
                count_d = bus.load_value;
            end
        end else begin
            unique case (state_q)
                StRun, StPaused: begin
                    if (bus.pause) begin
                        state_d = StPaused;
                    end else begin
                        // Leaving pause counts on the same edge, so a pause of
                        // P edges delays completion by exactly P cycles.
                        state_d = StRun;
                        if (tick) begin
                            if (count_q == WIDTH'(1)) begin
                                done_d = 1'b1;
                                if (mode_q == MODE_PERIODIC) begin
                                    count_d = reload_q;
                                end else begin
                                    count_d = '0;
                                    state_d = StDone;
                                end
                            end else begin
                                count_d = count_q - WIDTH'(1);
                            end
                        end
                    end
                end
                StIdle: begin
                    count_d = '0;
                end
                StDone: begin
                    count_d = '0;
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                end
            endcase
        end
    end

    // Output logic, decoded from the next state and registered above.
    always_comb begin
        busy_d   = (state_d == StRun) || (state_d == StPaused);
        paused_d = (state_d == StPaused);
    end

    assign bus.count  = count_q;
    assign bus.busy   = busy_q;
    assign bus.paused = paused_q;
    assign bus.done   = done_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 10, bit width of the load value and the count.
REQ-002 Parameter TICK_DIV, default 1, number of Clock cycles per count decrement; legal range 1..65535.
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level sampled each edge; loads loadValue and begins countdown.
REQ-006 pause  input  1  level; freezes the countdown while high.
REQ-007 abort  input  1  level sampled each edge; returns the block to IDLE.
REQ-008 autoReload  input  1  sampled with start; 1 = periodic mode, 0 = one-shot mode.
REQ-009 loadValue  input  WIDTH  initial count value (counterSeconds of prior generation).
REQ-010 count  output  WIDTH  current remaining count, registered.
REQ-011 busy  output  1  high in RUN or PAUSED.
REQ-012 paused  output  1  high in PAUSED only.
REQ-013 done  output  1  registered one-cycle pulse at terminal tick.

Function
REQ-014 States: IDLE, RUN, PAUSED, DONE; all outputs registered.
REQ-015 Input priority per edge: abort > start > pause.
REQ-016 abort in any state: next state IDLE, count=0, prescaler=0, done=0, no done pulse.
REQ-017 start in any state (incl. RUN/PAUSED = restart): count<=loadValue, reloadReg<=loadValue, modeReg<=autoReload, prescaler<=0, state RUN.
REQ-018 start with loadValue==0: state DONE, count=0, done=1 on the same edge; busy stays 0; autoReload ignored.
REQ-019 RUN: prescaler increments each edge 0..TICK_DIV-1; on edge where prescaler==TICK_DIV-1 it wraps to 0 and count decrements by 1.
REQ-020 TICK_DIV==1: count decrements on every RUN edge.
REQ-021 Latency: start sampled at edge k with value N>0 and no pause -> count==N-1 after edge k+TICK_DIV; done==1 for exactly the cycle after edge k+N*TICK_DIV.
REQ-022 Terminal tick (count==1 and decrement due), one-shot: count<=0, done<=1, state DONE, busy<=0 on that edge.
REQ-023 Terminal tick, periodic: count<=reloadReg, prescaler<=0, done<=1, state stays RUN; period N*TICK_DIV cycles.
REQ-024 pause high in RUN (no start/abort): state PAUSED; count and prescaler hold; no decrement on that edge.
REQ-025 pause low in PAUSED: state RUN; counting resumes from held prescaler value on next edge.
REQ-026 pause in IDLE or DONE: ignored.
REQ-027 DONE: count holds 0; done low after its single pulse; stays until start or abort.
REQ-028 Count never wraps below 0; no decrement in IDLE, PAUSED or DONE.

Reset
REQ-029 Reset low: immediately, independent of Clock, state=IDLE, count=0, prescaler=0, reloadReg=0, modeReg=0, busy=0, paused=0, done=0.
REQ-030 Reset asserted mid-countdown discards all progress; after release, no activity until the next start.

Structure
REQ-031 Package countdown_timer_pkg holds the state enumeration and the MODE_ONESHOT/MODE_PERIODIC constants.
REQ-032 Sub-module tick_prescaler (parameter TICK_DIV; inputs Clock, Reset, clear, enable; output tick) generates the decrement strobe.
REQ-033 Prescaler width is ceil(log2(TICK_DIV)), minimum 1.

Verification (WIDTH=10, TICK_DIV=2 unless stated)
REQ-034 Reset low 2 cycles, release, start=1 loadValue=7 one-shot -> count 7,7,6,6,...,1,1,0; done single pulse 14 cycles after start edge; busy falls on same edge.
REQ-035 loadValue=7 one-shot, pause high 5 cycles after count reaches 5 -> paused=1, count frozen at 5; done delayed to 19 cycles after start.
REQ-036 autoReload=1, loadValue=3 -> done pulses every 6 cycles, count reloads to 3, busy stays high; abort -> IDLE, count=0, no further pulses.
REQ-037 loadValue=0 start -> done=1 one cycle later, busy never high; start+abort same edge -> IDLE, count=0.
REQ-038 Reset asserted asynchronously mid-cycle at count=4 -> outputs zero before next edge; idle after release.
REQ-039 TICK_DIV=1, loadValue=1023 one-shot; restart with loadValue=2 at count=500 -> done exactly 2 cycles after restart edge.
